// File: rtl/mem_pkg.sv
// Shared types and default sizing for the mem_2p_pipe dual-port data memory.
package mem_pkg;

  typedef enum logic {
    READ_FIRST,
    WRITE_FIRST
  } rdw_mode_e;

  typedef enum logic {
    INIT,
    RUN
  } mem_state_e;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 10;
  localparam int unsigned DEF_RD_LATENCY = 1;

endpackage

// File: rtl/mem_lat_pipe.sv
// Read-latency pipeline: LATENCY-deep valid/data shift with synchronous clear.
// Data stages load only behind a valid, so the output word holds between reads.
module mem_lat_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  i_clr,
  input  logic                  i_vld,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_vld,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [LATENCY-1:0]    r_vld;
  logic [DATA_WIDTH-1:0] r_data [LATENCY];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_vld <= '0;
      for (int k = 0; k < LATENCY; k++) r_data[k] <= '0;
    end else begin
      r_vld[0] <= i_vld;
      if (i_vld) r_data[0] <= i_data;
      for (int k = 1; k < LATENCY; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) r_data[k] <= r_data[k-1];
      end
    end
  end

  assign o_vld  = r_vld[LATENCY-1];
  assign o_data = r_data[LATENCY-1];

endmodule

// File: rtl/mem_2p_pipe.sv
// True dual-port byte-enabled data memory with zero-init sweep, configurable
// read latency and a defined cross-port collision policy (A = LSU, B = debug/DMA).
module mem_2p_pipe
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned RD_LATENCY = DEF_RD_LATENCY,
  parameter rdw_mode_e   RDW_MODE   = READ_FIRST,
  localparam int unsigned DEPTH            = 2 ** ADDR_WIDTH,
  localparam int unsigned BYTEENABLE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        ready_o,
  input  logic                        req_a,
  input  logic                        we_a,
  input  logic [ADDR_WIDTH-1:0]       addr_a,
  input  logic [DATA_WIDTH-1:0]       wr_data_a,
  input  logic [BYTEENABLE_WIDTH-1:0] byteenable_a,
  output logic                        rd_valid_a,
  output logic [DATA_WIDTH-1:0]       rd_data_a,
  input  logic                        req_b,
  input  logic                        we_b,
  input  logic [ADDR_WIDTH-1:0]       addr_b,
  input  logic [DATA_WIDTH-1:0]       wr_data_b,
  input  logic [BYTEENABLE_WIDTH-1:0] byteenable_b,
  output logic                        rd_valid_b,
  output logic [DATA_WIDTH-1:0]       rd_data_b,
  output logic                        collision_o
);

  mem_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_init_cnt;
  logic                  r_ready;
  logic                  r_collision;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_acc_a, w_acc_b, w_wr_a, w_wr_b, w_rd_a, w_rd_b;
  logic w_act_a, w_act_b, w_same_addr, w_collision;
  logic [DATA_WIDTH-1:0] w_rd_word_a, w_rd_word_b;

  // A byteenable of zero on a write is a no-op: not an access at all.
  assign w_acc_a     = req_a & r_ready & ~rst;
  assign w_acc_b     = req_b & r_ready & ~rst;
  assign w_wr_a      = w_acc_a & we_a & (|byteenable_a);
  assign w_wr_b      = w_acc_b & we_b & (|byteenable_b);
  assign w_rd_a      = w_acc_a & ~we_a;
  assign w_rd_b      = w_acc_b & ~we_b;
  assign w_act_a     = w_wr_a | w_rd_a;
  assign w_act_b     = w_wr_b | w_rd_b;
  assign w_same_addr = (addr_a == addr_b);
  assign w_collision = w_act_a & w_act_b & w_same_addr & (w_wr_a | w_wr_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= INIT;
      r_init_cnt  <= '0;
      r_ready     <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      r_collision <= w_collision;
      case (r_state)
        INIT: begin
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == '1) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        RUN:     r_state <= RUN;
        default: r_state <= INIT;
      endcase
    end
  end

  // NOTE: the array has no reset; contents are cleared by the INIT sweep,
  // which keeps the storage mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      r_mem[r_init_cnt] <= '0;
    end else begin
      for (int i = 0; i < BYTEENABLE_WIDTH; i++) begin
        // A is assigned last so it wins any lane both ports enable.
        if (w_wr_b && byteenable_b[i]) r_mem[addr_b][i*8 +: 8] <= wr_data_b[i*8 +: 8];
        if (w_wr_a && byteenable_a[i]) r_mem[addr_a][i*8 +: 8] <= wr_data_a[i*8 +: 8];
      end
    end
  end

  // NOTE: both read words get a default before any conditional override,
  // so this block never infers a latch.
  always_comb begin
    w_rd_word_a = r_mem[addr_a];
    w_rd_word_b = r_mem[addr_b];
    if (RDW_MODE == WRITE_FIRST && w_same_addr) begin
      for (int i = 0; i < BYTEENABLE_WIDTH; i++) begin
        if (w_wr_b && byteenable_b[i]) w_rd_word_a[i*8 +: 8] = wr_data_b[i*8 +: 8];
        if (w_wr_a && byteenable_a[i]) w_rd_word_b[i*8 +: 8] = wr_data_a[i*8 +: 8];
      end
    end
  end

  mem_lat_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(RD_LATENCY)) u_pipe_a (
    .clk    (clk),
    .i_clr  (rst),
    .i_vld  (w_rd_a),
    .i_data (w_rd_word_a),
    .o_vld  (rd_valid_a),
    .o_data (rd_data_a)
  );

  mem_lat_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(RD_LATENCY)) u_pipe_b (
    .clk    (clk),
    .i_clr  (rst),
    .i_vld  (w_rd_b),
    .i_data (w_rd_word_b),
    .o_vld  (rd_valid_b),
    .o_data (rd_data_b)
  );

  assign ready_o     = r_ready;
  assign collision_o = r_collision;

endmodule

// File: tb/tb_mem_2p_pipe.sv
// Scoreboard bench: two DUTs (latency 1 / READ_FIRST, latency 2 / WRITE_FIRST)
// share one stimulus stream; a reference memory model predicts every read.
module tb_mem_2p_pipe;
  import mem_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_a, we_a, req_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wr_data_a, wr_data_b;
  logic [BW-1:0] byteenable_a, byteenable_b;

  logic          ready0, rv_a0, rv_b0, coll0;
  logic [DW-1:0] rd_a0, rd_b0;
  logic          ready1, rv_a1, rv_b1, coll1;
  logic [DW-1:0] rd_a1, rd_b1;

  mem_2p_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .RDW_MODE(READ_FIRST)) dut0 (
    .clk(clk), .rst(rst), .ready_o(ready0),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wr_data_a(wr_data_a),
    .byteenable_a(byteenable_a), .rd_valid_a(rv_a0), .rd_data_a(rd_a0),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wr_data_b(wr_data_b),
    .byteenable_b(byteenable_b), .rd_valid_b(rv_b0), .rd_data_b(rd_b0),
    .collision_o(coll0)
  );

  mem_2p_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .RDW_MODE(WRITE_FIRST)) dut1 (
    .clk(clk), .rst(rst), .ready_o(ready1),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wr_data_a(wr_data_a),
    .byteenable_a(byteenable_a), .rd_valid_a(rv_a1), .rd_data_a(rd_a1),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wr_data_b(wr_data_b),
    .byteenable_b(byteenable_b), .rd_valid_b(rv_b1), .rd_data_b(rd_b1),
    .collision_o(coll1)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  typedef struct {
    bit            req;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } op_t;

  // Queue index: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B.
  exp_t          q [4][$];
  logic [DW-1:0] mem_m [DEPTH];
  int            vectors     = 0;
  int            miscompares = 0;
  int            cyc         = 0;
  bit            exp_coll    = 1'b0;
  bit            mon_en      = 1'b0;
  op_t           idle_op     = '{default: '0};

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic op_t rd(input int ad);
    op_t o;
    o = '{req: 1'b1, we: 1'b0, addr: AW'(ad), data: '0, be: '0};
    return o;
  endfunction

  function automatic op_t wr(input int ad, input logic [DW-1:0] d, input logic [BW-1:0] be);
    op_t o;
    o = '{req: 1'b1, we: 1'b1, addr: AW'(ad), data: d, be: be};
    return o;
  endfunction

  // Word a read of `r` returns while `oth` is on the other port this cycle.
  function automatic logic [DW-1:0] rd_exp(input bit wf, input op_t r, input op_t oth);
    logic [DW-1:0] w;
    w = mem_m[r.addr];
    if (wf && oth.req && oth.we && oth.addr == r.addr)
      for (int i = 0; i < BW; i++)
        if (oth.be[i]) w[i*8 +: 8] = oth.data[i*8 +: 8];
    return w;
  endfunction

  task automatic drive(input op_t a, input op_t b);
    req_a = a.req; we_a = a.we; addr_a = a.addr; wr_data_a = a.data; byteenable_a = a.be;
    req_b = b.req; we_b = b.we; addr_b = b.addr; wr_data_b = b.data; byteenable_b = b.be;
  endtask

  task automatic step(input op_t a, input op_t b);
    bit act_a, act_b, wr_a, wr_b;
    drive(a, b);
    @(posedge clk);
    if (a.req && !a.we) begin
      q[0].push_back('{data: rd_exp(1'b0, a, b), due: cyc + 1});
      q[2].push_back('{data: rd_exp(1'b1, a, b), due: cyc + 2});
    end
    if (b.req && !b.we) begin
      q[1].push_back('{data: rd_exp(1'b0, b, a), due: cyc + 1});
      q[3].push_back('{data: rd_exp(1'b1, b, a), due: cyc + 2});
    end
    wr_a  = a.req && a.we && (a.be != '0);
    wr_b  = b.req && b.we && (b.be != '0);
    act_a = wr_a || (a.req && !a.we);
    act_b = wr_b || (b.req && !b.we);
    exp_coll = act_a && act_b && (a.addr == b.addr) && (wr_a || wr_b);
    for (int i = 0; i < BW; i++) begin
      if (wr_b && b.be[i]) mem_m[b.addr][i*8 +: 8] = b.data[i*8 +: 8];
    end
    for (int i = 0; i < BW; i++) begin
      if (wr_a && a.be[i]) mem_m[a.addr][i*8 +: 8] = a.data[i*8 +: 8];
    end
    #1 drive(idle_op, idle_op);
  endtask

  // Counts edges after rst release until ready_o; optionally pokes a write
  // to address 9 while the sweep runs, which must be ignored.
  task automatic wait_ready(input bit poke);
    int n;
    n = 0;
    if (poke) drive(wr(9, 32'hFFFF_FFFF, 4'hF), idle_op);
    while (n < 100) begin
      @(posedge clk);
      #1 n++;
      if (ready0) break;
    end
    drive(idle_op, idle_op);
    check("ready_low_cycles", DW'(n), 32'd16);
    check("ready1_high", DW'(ready1), 32'd1);
  endtask

  task automatic mon_port(input int k, input string tag, input logic v, input logic [DW-1:0] d);
    exp_t e;
    if (v) begin
      if (q[k].size() == 0) begin
        check({tag, "_spurious_valid"}, 32'd1, 32'd0);
      end else begin
        e = q[k].pop_front();
        check({tag, "_data"}, d, e.data);
        check({tag, "_valid_cycle"}, DW'(cyc), DW'(e.due));
      end
    end else if (q[k].size() != 0 && q[k][0].due <= cyc) begin
      e = q[k].pop_front();
      check({tag, "_missing_valid"}, 32'd0, 32'd1);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      mon_port(0, "a0", rv_a0, rd_a0);
      mon_port(1, "b0", rv_b0, rd_b0);
      mon_port(2, "a1", rv_a1, rd_a1);
      mon_port(3, "b1", rv_b1, rd_b1);
      check("collision0", DW'(coll0), DW'(exp_coll));
      check("collision1", DW'(coll1), DW'(exp_coll));
      exp_coll = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive(idle_op, idle_op);
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

    // Reset state and init sweep length.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready0", DW'(ready0), 32'd0);
    check("rst_ready1", DW'(ready1), 32'd0);
    check("rst_rv_a0", DW'(rv_a0), 32'd0);
    check("rst_rv_b1", DW'(rv_b1), 32'd0);
    check("rst_rd_a0", rd_a0, 32'd0);
    check("rst_rd_b1", rd_b1, 32'd0);
    check("rst_coll0", DW'(coll0), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    wait_ready(1'b0);

    // Swept contents read back as zero.
    for (int i = 0; i < DEPTH; i++) step(rd(i), idle_op);

    // Partial byte write, cross-port read.
    step(wr(3, 32'hDEAD_BEEF, 4'b0011), idle_op);
    step(idle_op, rd(3));

    // Dual write to one address, A wins shared lanes.
    step(wr(5, 32'h1111_1111, 4'b0011), wr(5, 32'h2222_2222, 4'b1110));
    step(rd(5), idle_op);
    // Zero-enable write is neither an access nor a collision.
    step(wr(5, 32'hFFFF_FFFF, 4'b0000), rd(5));

    // Read-during-write across ports, both directions.
    step(wr(7, 32'hAAAA_AAAA, 4'hF), idle_op);
    step(wr(7, 32'h5555_5555, 4'hF), rd(7));
    step(idle_op, rd(7));
    step(rd(7), wr(7, 32'h1234_5678, 4'b0110));
    step(rd(7), idle_op);

    // Fill then back-to-back dual streaming reads.
    for (int i = 0; i < DEPTH; i++) step(wr(i, DW'(i) * 32'h0101_0101, 4'hF), idle_op);
    for (int i = 0; i < DEPTH; i++) step(rd(i), rd(i));

    // Reset in the middle of a stream.
    for (int i = 0; i < 6; i++) step(rd(i), rd(i));
    drive(rd(6), rd(6));
    rst = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) q[k].delete();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    #2;
    check("midrst_rv_a0", DW'(rv_a0), 32'd0);
    check("midrst_rv_b0", DW'(rv_b0), 32'd0);
    check("midrst_rv_a1", DW'(rv_a1), 32'd0);
    check("midrst_rv_b1", DW'(rv_b1), 32'd0);
    check("midrst_ready0", DW'(ready0), 32'd0);
    rst = 1'b0;
    drive(idle_op, idle_op);
    wait_ready(1'b1);
    step(rd(9), rd(9));

    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("drain_q%0d", k), DW'(q[k].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_2p_pipe.md
Name: mem_2p_pipe

Overview:
- Parametrised true dual-port, byte-enabled data memory; successor to mem_2p for the RV32IMAC core.
- Adds configurable read latency, per-port request/valid handshake, and a defined cross-port collision policy with a flag.
- Adds a hardware zero-initialisation sweep after reset.
- Port A serves the core LSU; port B serves the debug/DMA path.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, word address width.
- DEPTH, 2**ADDR_WIDTH, number of words (localparam, derived).
- BYTEENABLE_WIDTH, DATA_WIDTH/8, byte lanes (localparam, derived).
- RD_LATENCY, 1, accept-to-data latency in cycles; legal values 1 or 2.
- RDW_MODE, READ_FIRST, cross-port read-during-write policy (READ_FIRST or WRITE_FIRST).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- ready_o  out  1  high once init sweep done; requests accepted only when high.
- req_a  in  1  port A request.
- we_a  in  1  port A write (1) / read (0).
- addr_a  in  ADDR_WIDTH  port A word address.
- wr_data_a  in  DATA_WIDTH  port A write data.
- byteenable_a  in  BYTEENABLE_WIDTH  port A lane enables.
- rd_valid_a  out  1  port A read data valid.
- rd_data_a  out  DATA_WIDTH  port A read data.
- req_b, we_b, addr_b, wr_data_b, byteenable_b, rd_valid_b, rd_data_b: identical set for port B.
- collision_o  out  1  one-cycle pulse on a same-address, same-cycle A/B access with at least one write.

Behaviour:
- Reset values: ready_o=0, rd_valid_a/b=0, rd_data_a/b=0, collision_o=0, latency pipelines cleared.
- FSM states INIT and RUN.
  - rst forces INIT and sets the sweep counter to 0.
  - In INIT, writes 0 to word[counter] each cycle; after DEPTH cycles moves to RUN.
  - ready_o is registered high on entry to RUN: low for exactly DEPTH cycles after rst deasserts.
- Accept: request at an edge where req_x & ready_o. Requests while ready_o=0 are ignored and lost.
- Write: bytes with byteenable_x[i]=1 are updated at the accepting edge. byteenable=0 is a no-op, produces no rd_valid, and cannot flag a collision.
- Read: data is the word at the accepting edge.
  - rd_valid_x is high for one cycle, RD_LATENCY cycles after acceptance.
  - Full throughput: one read per port per cycle, in order.
  - rd_data_x holds its last value when rd_valid_x=0.
  - Writes never raise rd_valid.
- Same-port read and write cannot coincide: one op per port per cycle.
- Dual write to the same address:
  - Per byte lane, A wins where both ports enable the lane; otherwise the enabling port's byte is written.
  - collision_o=1 in the following cycle.
- Cross-port read/write to the same address:
  - READ_FIRST: the reader gets the pre-write word.
  - WRITE_FIRST: the reader gets the word with the other port's enabled bytes merged.
  - collision_o=1 in the following cycle.
- Dual read of the same address: legal, no collision flag.
- Reset mid-operation:
  - In-flight reads are dropped; rd_valid deasserts the cycle after the rst edge.
  - The sweep restarts from 0 and all contents return to zero.
- Storage: inferred RAM, one write-port process with byte-lane loop; no asynchronous reset on the array.

Decomposition:
- Package mem_pkg:
  - rdw_mode_e enum (READ_FIRST, WRITE_FIRST).
  - mem_state_e enum (INIT, RUN).
  - Default width constants.
- Sub-module mem_lat_pipe, instantiated once per port: RD_LATENCY-deep valid/data shift pipeline with synchronous clear.

Test Plan:
- Config for all tests: ADDR_WIDTH=4, DEPTH=16.
1. rst high 3 cycles, release -> ready_o low exactly 16 cycles then high; reads of addresses 0..15 on A all return 0x00000000.
2. A write addr 3 data 0xDEADBEEF be 4'b0011, then B read addr 3 -> rd_data_b=0x0000BEEF. rd_valid_b is high 1 cycle after accept (RD_LATENCY=1) and 2 cycles after (RD_LATENCY=2).
3. Same cycle, addr 5: A writes 0x11111111 be 0011, B writes 0x22222222 be 1110 -> collision_o pulses once; a later read returns 0x22221111.
4. Preload addr 7=0xAAAAAAAA. Same cycle, A writes 0x55555555 be 1111 and B reads 7:
   - READ_FIRST: B gets 0xAAAAAAAA.
   - WRITE_FIRST: B gets 0x55555555.
   - In both modes collision_o=1, and a later read returns 0x55555555.
5. Both ports stream reads of addresses 0..15 back-to-back after writing word[i]=i*0x01010101 -> rd_valid continuous for 16 cycles per port, data in address order, collision_o stays 0.
6. rst asserted mid-stream of test 5 -> rd_valid_a/b low the next cycle, ready_o low for 16 cycles, and a subsequent read of addr 9 returns 0x00000000.
